valid_register_bank: RTL
========================

# valid_register_bank

Parametrised bank of NrOfWords registers, each NrOfBits wide with its own valid bit, for the digit-recognition datapath: feature words, partial sums and layer outputs that the single valid register can hold only one of at a time. One write port (random or shift-in), one registered read port, bank-wide clear and preset, and a live valid-entry count. Writes are qualified by ClockEnable & Tick, as in the rest of the memory library.

## Interface
- NrOfBits, 8, data width per entry (1..32)
- NrOfWords, 4, number of entries (2..16)
- AddrBits, 2, address width; 2^AddrBits >= NrOfWords
- Clock  in  1  sole clock, all state on rising edge
- Reset  in  1  synchronous, active-low
- ClockEnable  in  1  write qualifier
- Tick  in  1  write qualifier, ANDed with ClockEnable
- Clear  in  1  invalidate all entries, zero data
- Preset  in  1  all data to all-ones, all valid
- ShiftEn  in  1  shift mode: entry0 <= D, entry i <= entry i-1
- WrEn  in  1  random write of D to WrAddr
- WrAddr  in  AddrBits  write address
- D  in  NrOfBits  write data
- RdEn  in  1  read request
- RdAddr  in  AddrBits  read address
- cs  in  1  deselect; high forces read outputs to zero
- Q  out  NrOfBits  read data, registered
- QValid  out  1  valid bit of the entry read
- RdAck  out  1  one-cycle read response strobe
- ValidMask  out  NrOfWords  per-entry valid bits, bit i = entry i
- Count  out  AddrBits+1  number of valid entries

## Operation
- Reset low: all data 0, all valid 0, Q=0, QValid=0, RdAck=0, ValidMask=0, Count=0.
- Update priority on each edge: Reset > Clear > Preset > Shift > Write.
- Clear and Preset act regardless of ClockEnable/Tick; Clear data 0/valid 0, Preset data all-ones/valid 1.
- Shift (ShiftEn & ClockEnable & Tick): entry0 <= D, valid0 <= 1; entry i <= entry i-1 incl. valid; top entry discarded. WrEn ignored that cycle.
- Write (WrEn & ClockEnable & Tick, no shift): entry[WrAddr] <= D, valid <= 1. WrAddr >= NrOfWords: no effect.
- Read: RdEn sampled every edge, ungated by Tick. Next cycle RdAck=1, Q=entry[RdAddr], QValid=valid[RdAddr]. RdAddr >= NrOfWords: Q=0, QValid=0, RdAck=1. Without RdEn: RdAck=0, Q and QValid hold.
- cs high: Q and QValid combinationally 0; RdAck unaffected; storage unaffected.
- Count = popcount of ValidMask, registered alongside the state it describes.
- Same-edge read and update of the same entry: read returns pre-update value unless the bypass macro is defined.

## Timing
- Write/shift/clear/preset visible in ValidMask and Count one cycle after the edge.
- Read latency 1 cycle; back-to-back RdEn gives one response per cycle.
- Reset mid-read: pending response dropped, RdAck=0 next cycle.
- Clear and Preset both high: Clear wins.
- Tick low: writes and shifts stall, reads continue.

## Configuration
- VALID_REGISTER_BANK_BYPASS_EN defined: read of an entry written or shifted on the same edge returns the new D/valid. Clear/Preset are also forwarded.
- Undefined: no forwarding; old value returned; no bypass mux.

## Test plan
- Reset low 2 cycles after random writes -> Q=0, ValidMask=0, Count=0.
- NrOfBits=8, NrOfWords=4: write 0x11,0x22,0x33 to addr 0,1,2, Tick=1 -> ValidMask=0b0111, Count=3; read addr 1 -> next cycle RdAck=1, Q=0x22, QValid=1; read addr 3 -> Q=0x00, QValid=0.
- ShiftEn with D=0xA0,0xA1,0xA2,0xA3,0xA4 -> entries 3..0 = 0xA1,0xA2,0xA3,0xA4, Count=4; WrEn asserted during shift is ignored.
- Preset then Clear on the next edge -> Count 4 then 0; Clear and Preset together -> Count=0; Tick=0 with WrEn -> no change.
- Write 0x55 to addr 2 and read addr 2 on the same edge -> old value without the macro, 0x55 with VALID_REGISTER_BANK_BYPASS_EN; cs=1 -> Q=0, QValid=0, RdAck=1.

Source files
------------

// File: rtl/valid_register_bank_if.sv
// rtl/valid_register_bank_if.sv - bus bundle for valid_register_bank (write, read, status)
interface valid_register_bank_if #(
  parameter int NrOfBits  = 8,
  parameter int NrOfWords = 4,
  parameter int AddrBits  = 2
);
  logic                ClockEnable;
  logic                Tick;
  logic                Clear;
  logic                Preset;
  logic                ShiftEn;
  logic                WrEn;
  logic [AddrBits-1:0] WrAddr;
  logic [NrOfBits-1:0] D;
  logic                RdEn;
  logic [AddrBits-1:0] RdAddr;
  logic                cs;
  logic [NrOfBits-1:0] Q;
  logic                QValid;
  logic                RdAck;
  logic [NrOfWords-1:0] ValidMask;
  logic [AddrBits:0]   Count;

  modport master (
    output ClockEnable, Tick, Clear, Preset, ShiftEn, WrEn, WrAddr, D, RdEn, RdAddr, cs,
    input  Q, QValid, RdAck, ValidMask, Count
  );

  modport slave (
    input  ClockEnable, Tick, Clear, Preset, ShiftEn, WrEn, WrAddr, D, RdEn, RdAddr, cs,
    output Q, QValid, RdAck, ValidMask, Count
  );
endinterface

// File: rtl/valid_register_bank.sv
// rtl/valid_register_bank.sv - bank of valid-tagged registers; VALID_REGISTER_BANK_BYPASS_EN forwards same-edge updates to reads
module valid_register_bank #(
  parameter int NrOfBits  = 8,
  parameter int NrOfWords = 4,
  parameter int AddrBits  = 2
) (
  input logic Clock,
  input logic Reset,
  valid_register_bank_if.slave bus
);

  localparam logic [AddrBits:0] Words = (AddrBits + 1)'(NrOfWords);

  logic [NrOfBits-1:0]  mem      [NrOfWords];
  logic [NrOfBits-1:0]  mem_next [NrOfWords];
  logic [NrOfWords-1:0] valid;
  logic [NrOfWords-1:0] valid_next;
  logic [AddrBits:0]    count;
  logic [AddrBits:0]    count_next;
  logic [NrOfBits-1:0]  q_reg;
  logic                 qvalid_reg;
  logic                 rd_ack;
  logic [NrOfBits-1:0]  rd_data;
  logic                 rd_valid;
  logic                 upd_en;
  logic                 wr_in_range;
  logic                 rd_in_range;

  assign upd_en      = bus.ClockEnable & bus.Tick;
  assign wr_in_range = {1'b0, bus.WrAddr} < Words;
  assign rd_in_range = {1'b0, bus.RdAddr} < Words;

  // Next storage state, priority Clear > Preset > Shift > Write
  always_comb begin
    mem_next   = mem;
    valid_next = valid;
    if (bus.Clear) begin
      for (int i = 0; i < NrOfWords; i++) mem_next[i] = '0;
      valid_next = '0;
    end else if (bus.Preset) begin
      for (int i = 0; i < NrOfWords; i++) mem_next[i] = '1;
      valid_next = '1;
    end else if (upd_en && bus.ShiftEn) begin
      mem_next[0] = bus.D;
      for (int i = 1; i < NrOfWords; i++) mem_next[i] = mem[i-1];
      valid_next = {valid[NrOfWords-2:0], 1'b1};
    end else if (upd_en && bus.WrEn && wr_in_range) begin
      mem_next[bus.WrAddr]   = bus.D;
      valid_next[bus.WrAddr] = 1'b1;
    end
  end

  // Population count of the next valid mask so Count lands with the mask
  always_comb begin
    count_next = '0;
    for (int i = 0; i < NrOfWords; i++) count_next = count_next + (AddrBits + 1)'(valid_next[i]);
  end

  // Read source: current contents, or the post-update contents when forwarding
  always_comb begin
    rd_data  = '0;
    rd_valid = 1'b0;
    if (rd_in_range) begin
`ifdef VALID_REGISTER_BANK_BYPASS_EN
      rd_data  = mem_next[bus.RdAddr];
      rd_valid = valid_next[bus.RdAddr];
`else
      rd_data  = mem[bus.RdAddr];
      rd_valid = valid[bus.RdAddr];
`endif
    end
  end

  // Storage, status and read-port registers
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      for (int i = 0; i < NrOfWords; i++) mem[i] <= '0;
      valid      <= '0;
      count      <= '0;
      q_reg      <= '0;
      qvalid_reg <= 1'b0;
      rd_ack     <= 1'b0;
    end else begin
      for (int i = 0; i < NrOfWords; i++) mem[i] <= mem_next[i];
      valid  <= valid_next;
      count  <= count_next;
      rd_ack <= bus.RdEn;
      if (bus.RdEn) begin
        q_reg      <= rd_data;
        qvalid_reg <= rd_valid;
      end
    end
  end

  assign bus.Q         = bus.cs ? '0 : q_reg;
  assign bus.QValid    = bus.cs ? 1'b0 : qvalid_reg;
  assign bus.RdAck     = rd_ack;
  assign bus.ValidMask = valid;
  assign bus.Count     = count;

endmodule
